// File: rtl/conv_channel_accum_param_if.sv
// conv_channel_accum_param_if: partial-sum stream, bias load and result bundle
interface conv_channel_accum_param_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] pxl_in;
   logic                  stride2;
   logic                  relu_en;
   logic                  valid_bias_in;
   logic [DATA_WIDTH-1:0] bias_in;
   logic [DATA_WIDTH-1:0] pxl_out;
   logic                  valid_out;
   logic                  frame_done;
   modport master (
      output valid_in, pxl_in, stride2, relu_en, valid_bias_in, bias_in,
      input  pxl_out, valid_out, frame_done
   );
   modport slave (
      input  valid_in, pxl_in, stride2, relu_en, valid_bias_in, bias_in,
      output pxl_out, valid_out, frame_done
   );
endinterface

// File: rtl/conv_channel_accum_param.sv
// conv_channel_accum_param: per-output-channel partial-sum accumulation with bias, ReLU, saturation and stride-2 decimation
module conv_channel_accum_param #(
   parameter int DATA_WIDTH      = 16,
   parameter int CHANNEL_NUM_IN  = 256,
   parameter int CHANNEL_NUM_OUT = 256,
   parameter int IMAGE_WIDTH     = 256,
   parameter int IMAGE_HEIGHT    = 256,
   parameter int ACC_WIDTH       = DATA_WIDTH + $clog2(CHANNEL_NUM_IN) + 2
) (
   input logic                      clk,
   input logic                      reset,
   conv_channel_accum_param_if.slave bus
);
   localparam int CIW = CHANNEL_NUM_IN  > 1 ? $clog2(CHANNEL_NUM_IN)  : 1;
   localparam int COW = CHANNEL_NUM_OUT > 1 ? $clog2(CHANNEL_NUM_OUT) : 1;
   localparam int XW  = IMAGE_WIDTH     > 1 ? $clog2(IMAGE_WIDTH)     : 1;
   localparam int YW  = IMAGE_HEIGHT    > 1 ? $clog2(IMAGE_HEIGHT)    : 1;
   localparam logic [CIW-1:0] CI_MAX = CIW'(CHANNEL_NUM_IN - 1);
   localparam logic [COW-1:0] CO_MAX = COW'(CHANNEL_NUM_OUT - 1);
   localparam logic [XW-1:0]  X_MAX  = XW'(IMAGE_WIDTH - 1);
   localparam logic [YW-1:0]  Y_MAX  = YW'(IMAGE_HEIGHT - 1);
   localparam logic signed [ACC_WIDTH-1:0] MAXV = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] MINV = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic [CIW-1:0] ci;
   logic [COW-1:0] co, ptr;
   logic [XW-1:0]  col;
   logic [YW-1:0]  row;
   logic           stride_q, relu_q, stride_cur, relu_cur;
   logic           ci_last, co_last, col_last, row_last, first, finish;
   logic signed [ACC_WIDTH-1:0] acc, s1, px_ext, bias_ext, relu_v;
   logic [DATA_WIDTH-1:0] bias_rd, sat_d;
   logic           s1_valid, s1_relu, s1_fd;
   logic [DATA_WIDTH-1:0] bias_mem [CHANNEL_NUM_OUT];

   // position decode, frame-mode selection and result shaping
   always_comb begin
      ci_last    = ci == CI_MAX;
      co_last    = co == CO_MAX;
      col_last   = col == X_MAX;
      row_last   = row == Y_MAX;
      first      = ci == '0 && co == '0 && col == '0 && row == '0;
      finish     = bus.valid_in && ci_last;
      stride_cur = first ? bus.stride2 : stride_q;
      relu_cur   = first ? bus.relu_en : relu_q;
      px_ext     = {{(ACC_WIDTH-DATA_WIDTH){bus.pxl_in[DATA_WIDTH-1]}}, bus.pxl_in};
      bias_rd    = bias_mem[co];
      bias_ext   = {{(ACC_WIDTH-DATA_WIDTH){bias_rd[DATA_WIDTH-1]}}, bias_rd};
      relu_v     = (s1_relu && s1[ACC_WIDTH-1]) ? '0 : s1;
      sat_d      = relu_v > MAXV ? MAXV[DATA_WIDTH-1:0] : relu_v < MINV ? MINV[DATA_WIDTH-1:0] : relu_v[DATA_WIDTH-1:0];
   end

   // bias storage is deliberately left out of reset so loaded biases survive a frame abort
   always_ff @(posedge clk) begin
      if (bus.valid_bias_in) bias_mem[ptr] <= bus.bias_in;
   end

   // raster counters, frame-mode latch, accumulator and bias write pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ci       <= '0;
         co       <= '0;
         col      <= '0;
         row      <= '0;
         ptr      <= '0;
         stride_q <= 1'b0;
         relu_q   <= 1'b0;
         acc      <= '0;
      end else begin
         if (bus.valid_bias_in) ptr <= ptr == CO_MAX ? '0 : ptr + COW'(1);
         if (bus.valid_in) begin
            ci  <= ci_last ? '0 : ci + CIW'(1);
            acc <= ci == '0 ? px_ext : acc + px_ext;
            if (ci_last) co <= co_last ? '0 : co + COW'(1);
            if (ci_last && co_last) col <= col_last ? '0 : col + XW'(1);
            if (ci_last && co_last && col_last) row <= row_last ? '0 : row + YW'(1);
            if (first) begin
               stride_q <= bus.stride2;
               relu_q   <= bus.relu_en;
            end
         end
      end
   end

   // stage 1: final partial plus bias, with emit/relu/end-of-frame flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1       <= '0;
         s1_valid <= 1'b0;
         s1_relu  <= 1'b0;
         s1_fd    <= 1'b0;
      end else begin
         s1_valid <= finish && !(stride_cur && (row[0] || col[0]));
         s1_fd    <= finish && co_last && col_last && row_last;
         if (finish) begin
            s1      <= (ci == '0 ? '0 : acc) + px_ext + bias_ext;
            s1_relu <= relu_cur;
         end
      end
   end

   // stage 2: register the rectified, saturated result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.pxl_out    <= '0;
         bus.valid_out  <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.valid_out  <= s1_valid;
         bus.frame_done <= s1_fd;
         if (s1_valid) bus.pxl_out <= sat_d;
      end
   end
endmodule

// File: tb/tb_conv_channel_accum_param.sv
// tb_conv_channel_accum_param: directed table and frame-level checks of the channel accumulator
module tb_conv_channel_accum_param;
   typedef struct {int p0; int p1; int p2; int exp_v;} vec_t;
   typedef struct {int val; int cyc;} ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   vec_t vecs[14];
   ev_t  out_q[$];
   ev_t  exp_q[$];
   int   fd_q[$];

   conv_channel_accum_param_if #(.DATA_WIDTH(16)) bus();

   conv_channel_accum_param #(
      .DATA_WIDTH(16), .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2),
      .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.valid_out) out_q.push_back('{int'($signed(bus.pxl_out)), cyc});
      if (bus.frame_done) fd_q.push_back(cyc);
   end

   task automatic chk(input string name, input int act, input int exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   function automatic int golden(input int sum, input bit relu);
      int s = sum;
      if (relu && s < 0) s = 0;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   task automatic send_beat(input int v, input int gap);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.valid_in = 1'b1;
      bus.pxl_in   = 16'(v);
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
   endtask

   task automatic load_bias(input int b0, input int b1);
      bus.valid_bias_in = 1'b1;
      bus.bias_in = 16'(b0);
      @(posedge clk);
      #1;
      bus.bias_in = 16'(b1);
      @(posedge clk);
      #1;
      bus.valid_bias_in = 1'b0;
   endtask

   task automatic do_frame(input string tag, input int t0, input int nt, input bit relu,
                           input bit stride, input int gapmax, input int b0, input int b1);
      int k = 0;
      int p0, p1, p2, e, last;
      out_q.delete();
      exp_q.delete();
      fd_q.delete();
      bus.relu_en = relu;
      bus.stride2 = stride;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            for (int o = 0; o < 2; o++) begin
               if (k == 2) begin
                  bus.relu_en = !relu;
                  bus.stride2 = !stride;
               end
               if (k < nt) begin
                  p0 = vecs[t0+k].p0; p1 = vecs[t0+k].p1; p2 = vecs[t0+k].p2;
                  e = vecs[t0+k].exp_v;
               end else begin
                  p0 = gapmax > 0 ? int'($urandom_range(0, 4000)) - 2000 : 1;
                  p1 = gapmax > 0 ? int'($urandom_range(0, 4000)) - 2000 : 1;
                  p2 = gapmax > 0 ? int'($urandom_range(0, 4000)) - 2000 : 1;
                  e = golden(p0 + p1 + p2 + (o == 0 ? b0 : b1), relu);
               end
               send_beat(p0, gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
               send_beat(p1, gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
               send_beat(p2, gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
               if (!stride || (r % 2 == 0 && c % 2 == 0)) exp_q.push_back('{e, cyc + 1});
               k++;
            end
      last = cyc;
      repeat (4) @(posedge clk);
      #1;
      chk({tag, " result_count"}, out_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         chk($sformatf("%s value[%0d]", tag, i), out_q[i].val, exp_q[i].val);
         chk($sformatf("%s cycle[%0d]", tag, i), out_q[i].cyc, exp_q[i].cyc);
      end
      chk({tag, " frame_done_count"}, fd_q.size(), 1);
      if (fd_q.size() > 0) chk({tag, " frame_done_cycle"}, fd_q[0], last + 1);
   endtask

   initial begin
      vecs[0]  = '{1, 2, 3, 16};
      vecs[1]  = '{4, 5, 6, 10};
      vecs[2]  = '{-100, 20, 30, -40};
      vecs[3]  = '{30000, 30000, 30000, 32767};
      vecs[4]  = '{-30000, -30000, -30000, -32768};
      vecs[5]  = '{-100, 20, 30, -55};
      vecs[6]  = '{0, 0, 0, 10};
      vecs[7]  = '{7, -8, 9, 3};
      vecs[8]  = '{-100, 20, 30, 0};
      vecs[9]  = '{5, 5, 5, 15};
      vecs[10] = '{-1, -1, -1, 0};
      vecs[11] = '{30000, 30000, 30000, 32767};
      vecs[12] = '{-100, 20, 30, -43};
      vecs[13] = '{-30000, -30000, -30000, -32768};
      bus.valid_in = 1'b0;
      bus.pxl_in = '0;
      bus.stride2 = 1'b0;
      bus.relu_en = 1'b0;
      bus.valid_bias_in = 1'b0;
      bus.bias_in = '0;
      @(posedge clk);
      #1;
      chk("reset pxl_out", int'(bus.pxl_out), 0);
      chk("reset valid_out", int'(bus.valid_out), 0);
      chk("reset frame_done", int'(bus.frame_done), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      load_bias(10, -5);
      do_frame("basic", 0, 8, 1'b0, 1'b0, 0, 10, -5);
      load_bias(0, 0);
      do_frame("relu", 8, 4, 1'b1, 1'b0, 0, 0, 0);
      load_bias(7, -3);
      do_frame("stride", 12, 2, 1'b0, 1'b1, 2, 7, -3);
      out_q.delete();
      fd_q.delete();
      bus.relu_en = 1'b0;
      bus.stride2 = 1'b0;
      send_beat(100, 0);
      send_beat(100, 0);
      send_beat(100, 0);
      send_beat(50, 0);
      reset = 1'b1;
      #1;
      chk("abort valid_out", int'(bus.valid_out), 0);
      chk("abort pxl_out", int'(bus.pxl_out), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort no_output", out_q.size(), 0);
      send_beat(2, 0);
      send_beat(3, 0);
      send_beat(4, 0);
      exp_q.delete();
      exp_q.push_back('{16, cyc + 1});
      repeat (3) @(posedge clk);
      #1;
      chk("fresh result_count", out_q.size(), 1);
      if (out_q.size() > 0) begin
         chk("fresh value", out_q[0].val, exp_q[0].val);
         chk("fresh cycle", out_q[0].cyc, exp_q[0].cyc);
      end
      chk("fresh no_frame_done", fd_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
